hmac_tag_strip: RTL and testbench

Sits between the HMAC verification stage output and the host source stream (`axis_host_src`) in user logic. Each verified packet arrives with a one-beat verdict trailer flagged by `tlast`. The block removes that trailer and moves `tlast` onto the preceding payload beat. It also decodes the verdict and keeps per-verdict statistics.

---
 rtl/hmac_pkg.sv | 31 +++
 rtl/hmac_tag_strip_sat_counter.sv | 24 ++
 rtl/hmac_tag_strip.sv | 144 ++++++++++++++
 tb/tb_hmac_tag_strip.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hmac_pkg.sv
// Shared HMAC constants and types.
// Trailer verdict codes are shared with the verification stage that emits
// the one-beat trailer, so both ends agree on the encoding.
package hmac_pkg;

  localparam logic [7:0] HMAC_VERDICT_PASS = 8'hA5;
  localparam logic [7:0] HMAC_VERDICT_FAIL = 8'h5A;

  typedef enum logic [1:0] {
    PASS,
    FAIL,
    BAD
  } hmac_verdict_t;

  // Holding-register occupancy for the tag stripper.
  typedef enum logic {
    EMPTY,
    HOLD
  } hold_state_t;

  function automatic hmac_verdict_t hmac_decode(input logic [7:0] code);
    hmac_verdict_t v;
    case (code)
      HMAC_VERDICT_PASS: v = PASS;
      HMAC_VERDICT_FAIL: v = FAIL;
      default:           v = BAD;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/hmac_tag_strip_sat_counter.sv
// Saturating up-counter.
// Ports:
//   aclk   - clock
//   areset - synchronous active-high reset, clears the count
//   inc    - increment request for this cycle
//   cnt    - current count; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hmac_tag_strip.sv
// HMAC tag stripper.
// Removes the one-beat verdict trailer from each verified packet, moves tlast
// onto the last payload beat, reports the decoded verdict and keeps
// saturating pass/fail/error statistics.
// Ports:
//   aclk, areset          - clock, synchronous active-high reset
//   s_axis_*              - input stream from the verification stage
//   m_axis_*              - stripped stream toward the host
//   verdict_valid         - one-cycle pulse, cycle after a trailer is consumed
//   verdict_pass/tid      - decoded verdict and trailer tid (qualified)
//   pass_cnt/fail_cnt/err_cnt - saturating statistics
module hmac_tag_strip
  import hmac_pkg::*;
#(
  parameter int unsigned DATA_BITS = 512,
  parameter int unsigned KEEP_BITS = DATA_BITS / 8,
  parameter int unsigned ID_BITS   = 6,
  parameter int unsigned CNT_BITS  = 32
) (
  input  logic                 aclk,
  input  logic                 areset,

  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  input  logic [KEEP_BITS-1:0] s_axis_tkeep,
  input  logic [ID_BITS-1:0]   s_axis_tid,
  input  logic                 s_axis_tlast,

  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic [KEEP_BITS-1:0] m_axis_tkeep,
  output logic [ID_BITS-1:0]   m_axis_tid,
  output logic                 m_axis_tlast,

  output logic                 verdict_valid,
  output logic                 verdict_pass,
  output logic [ID_BITS-1:0]   verdict_tid,

  output logic [CNT_BITS-1:0]  pass_cnt,
  output logic [CNT_BITS-1:0]  fail_cnt,
  output logic [CNT_BITS-1:0]  err_cnt
);

  hold_state_t          state;
  logic                 held;
  logic [DATA_BITS-1:0] hold_data;
  logic [KEEP_BITS-1:0] hold_keep;
  logic [ID_BITS-1:0]   hold_tid;

  logic          s_hs;
  logic          trailer_hs;
  logic          tid_bad;
  hmac_verdict_t verdict;
  logic          inc_pass;
  logic          inc_fail;
  logic          inc_err;

  assign held = (state == HOLD);

  // A held beat is only released alongside its successor, so the successor's
  // tlast tells us whether the held beat ends the packet.
  assign s_axis_tready = held ? m_axis_tready : 1'b1;
  assign m_axis_tvalid = held & s_axis_tvalid;
  assign m_axis_tlast  = held & s_axis_tvalid & s_axis_tlast;
  assign m_axis_tdata  = hold_data;
  assign m_axis_tkeep  = hold_keep;
  assign m_axis_tid    = hold_tid;

  assign s_hs       = s_axis_tvalid & s_axis_tready;
  assign trailer_hs = s_hs & s_axis_tlast;
  assign tid_bad    = held & (s_axis_tid != hold_tid);
  assign verdict    = hmac_decode(s_axis_tdata[7:0]);

  // Exactly one statistic per consumed trailer; a tid mismatch overrides
  // whatever the trailer code says.
  always_comb begin
    inc_pass = 1'b0;
    inc_fail = 1'b0;
    inc_err  = 1'b0;
    if (trailer_hs) begin
      if (tid_bad) begin
        inc_err = 1'b1;
      end else begin
        case (verdict)
          PASS:    inc_pass = 1'b1;
          FAIL:    inc_fail = 1'b1;
          default: inc_err  = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= EMPTY;
      hold_data     <= '0;
      hold_keep     <= '0;
      hold_tid      <= '0;
      verdict_valid <= 1'b0;
      verdict_pass  <= 1'b0;
      verdict_tid   <= '0;
    end else begin
      verdict_valid <= trailer_hs;
      if (trailer_hs) begin
        verdict_pass <= inc_pass;
        verdict_tid  <= s_axis_tid;
      end
      if (s_hs) begin
        if (s_axis_tlast) begin
          state <= EMPTY;
        end else begin
          state     <= HOLD;
          hold_data <= s_axis_tdata;
          hold_keep <= s_axis_tkeep;
          hold_tid  <= s_axis_tid;
        end
      end
    end
  end

  sat_counter #(.WIDTH(CNT_BITS)) u_pass_cnt (
    .aclk   (aclk),
    .areset (areset),
    .inc    (inc_pass),
    .cnt    (pass_cnt)
  );

  sat_counter #(.WIDTH(CNT_BITS)) u_fail_cnt (
    .aclk   (aclk),
    .areset (areset),
    .inc    (inc_fail),
    .cnt    (fail_cnt)
  );

  sat_counter #(.WIDTH(CNT_BITS)) u_err_cnt (
    .aclk   (aclk),
    .areset (areset),
    .inc    (inc_err),
    .cnt    (err_cnt)
  );

endmodule

// File: tb/tb_hmac_tag_strip.sv
// Scoreboard bench for hmac_tag_strip: stimulus pushes expected output beats
// and verdicts into queues, a negedge monitor pops and compares them.
module tb_hmac_tag_strip;

  localparam int unsigned DB = 512;
  localparam int unsigned KB = DB / 8;
  localparam int unsigned IB = 6;
  localparam int unsigned CB = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_tvalid;
  logic          s_tready;
  logic [DB-1:0] s_tdata;
  logic [KB-1:0] s_tkeep;
  logic [IB-1:0] s_tid;
  logic          s_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [DB-1:0] m_tdata;
  logic [KB-1:0] m_tkeep;
  logic [IB-1:0] m_tid;
  logic          m_tlast;
  logic          verdict_valid;
  logic          verdict_pass;
  logic [IB-1:0] verdict_tid;
  logic [CB-1:0] pass_cnt;
  logic [CB-1:0] fail_cnt;
  logic [CB-1:0] err_cnt;

  hmac_tag_strip #(.DATA_BITS(DB), .ID_BITS(IB), .CNT_BITS(CB)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tid    (s_tid),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tid    (m_tid),
    .m_axis_tlast  (m_tlast),
    .verdict_valid (verdict_valid),
    .verdict_pass  (verdict_pass),
    .verdict_tid   (verdict_tid),
    .pass_cnt      (pass_cnt),
    .fail_cnt      (fail_cnt),
    .err_cnt       (err_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DB-1:0] data;
    logic [KB-1:0] keep;
    logic [IB-1:0] tid;
    logic          last;
  } beat_t;

  typedef struct {
    logic          pass;
    logic [IB-1:0] tid;
  } verd_t;

  beat_t exp_q[$];
  verd_t vrd_q[$];

  int vectors = 0;
  int miscompares = 0;
  int exp_pass = 0;
  int exp_fail = 0;
  int exp_err = 0;
  int pkt_no = 0;

  // 0: m_tready always 1, 1: toggle each cycle, 2: always 0
  int rdy_mode = 0;

  task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'b0;
    endcase
  end

  // Monitor: output beats, verdict pulses, and stall stability.
  logic          prev_stall = 1'b0;
  logic [DB+KB+IB:0] prev_m;

  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", m_tvalid, 1'b1);
        check("stall_stable", {m_tdata, m_tkeep, m_tid, m_tlast}, prev_m);
      end
      prev_stall = m_tvalid & ~m_tready;
      prev_m     = {m_tdata, m_tkeep, m_tid, m_tlast};
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("m_tdata", m_tdata, b.data);
          check("m_tkeep", m_tkeep, b.keep);
          check("m_tid", m_tid, b.tid);
          check("m_tlast", m_tlast, b.last);
        end
      end
      if (verdict_valid) begin
        if (vrd_q.size() == 0) begin
          check("unexpected_verdict", 1'b1, 1'b0);
        end else begin
          verd_t v;
          v = vrd_q.pop_front();
          check("verdict_pass", verdict_pass, v.pass);
          check("verdict_tid", verdict_tid, v.tid);
        end
      end
    end
  end

  function automatic logic [DB-1:0] make_data(input int pkt, input int idx);
    logic [DB-1:0] d;
    for (int w = 0; w < int'(DB / 32); w++) begin
      d[w*32 +: 32] = {8'(pkt), 8'(idx), 16'(w * 13 + 7)};
    end
    return d;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send_beat(input logic [DB-1:0] d, input logic [KB-1:0] k,
                           input logic [IB-1:0] id, input logic last);
    logic ok;
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tid    = id;
    s_tlast  = last;
    do begin
      @(negedge aclk);
      ok = s_tready;
      @(posedge aclk);
      #1;
      n++;
    end while (!ok && n < 1000);
    if (!ok) check("handshake_timeout", 1'b0, 1'b1);
    s_tvalid = 1'b0;
  endtask

  function automatic int sat_inc(input int c);
    return (c < 15) ? c + 1 : 15;
  endfunction

  // kind: 0 pass, 1 fail, 2 error (hand-decided per vector)
  task automatic send_packet(input int nbeats, input logic [IB-1:0] id,
                             input logic [IB-1:0] tr_id, input logic [7:0] code,
                             input logic vpass, input int kind);
    logic [DB-1:0] d;
    logic [KB-1:0] k;
    verd_t v;
    pkt_no++;
    for (int i = 0; i < nbeats; i++) begin
      beat_t b;
      d = make_data(pkt_no, i);
      k = '1;
      k = k >> i;
      b.data = d;
      b.keep = k;
      b.tid  = id;
      b.last = (i == nbeats - 1);
      exp_q.push_back(b);
      send_beat(d, k, id, 1'b0);
    end
    v.pass = vpass;
    v.tid  = tr_id;
    vrd_q.push_back(v);
    case (kind)
      0:       exp_pass = sat_inc(exp_pass);
      1:       exp_fail = sat_inc(exp_fail);
      default: exp_err  = sat_inc(exp_err);
    endcase
    d = make_data(pkt_no, 99);
    d[7:0] = code;
    send_beat(d, '1, tr_id, 1'b1);
  endtask

  task automatic check_counts(input string tag);
    repeat (3) @(posedge aclk);
    #1;
    check({tag, "_pass_cnt"}, pass_cnt, exp_pass[CB-1:0]);
    check({tag, "_fail_cnt"}, fail_cnt, exp_fail[CB-1:0]);
    check({tag, "_err_cnt"},  err_cnt,  exp_err[CB-1:0]);
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    exp_pass = 0;
    exp_fail = 0;
    exp_err  = 0;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge aclk);
    check({tag, "_s_tready"}, s_tready, 1'b1);
    check({tag, "_m_tvalid"}, m_tvalid, 1'b0);
    check({tag, "_m_tlast"}, m_tlast, 1'b0);
    check({tag, "_m_tdata"}, m_tdata, '0);
    check({tag, "_m_tid"}, m_tid, '0);
    check({tag, "_verdict_valid"}, verdict_valid, 1'b0);
    check({tag, "_cnts"}, {pass_cnt, fail_cnt, err_cnt}, '0);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tid    = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    rdy_mode = 2;
    @(posedge aclk);
    #1;
    do_reset();
    check_reset_state("por");

    // 3-beat pass packet, full throughput
    rdy_mode = 0;
    send_packet(3, 6'd1, 6'd1, 8'hA5, 1'b1, 0);
    check_counts("pass3");

    // 3-beat fail packet with toggling m_tready
    rdy_mode = 1;
    send_packet(3, 6'd2, 6'd2, 8'h5A, 1'b0, 1);
    check_counts("fail3");

    // Trailer-only pass packet
    rdy_mode = 0;
    send_packet(0, 6'd4, 6'd4, 8'hA5, 1'b1, 0);
    check_counts("tonly");

    // tid mismatch with a pass code
    send_packet(2, 6'd3, 6'd5, 8'hA5, 1'b0, 2);
    check_counts("tidmm");

    // Malformed trailer code
    rdy_mode = 1;
    send_packet(2, 6'd7, 6'd7, 8'h00, 1'b0, 2);
    check_counts("bad");

    // Reset while holding beat 1 of a 4-beat packet
    rdy_mode = 0;
    pkt_no++;
    send_beat(make_data(pkt_no, 0), '1, 6'd9, 1'b0);
    rdy_mode = 2;
    do_reset();
    check_reset_state("mid");
    rdy_mode = 1;
    send_packet(2, 6'd10, 6'd10, 8'hA5, 1'b1, 0);
    check_counts("post_rst");

    // Saturation: 17 more trailer-only pass packets, count stops at 4'hF
    rdy_mode = 0;
    for (int i = 0; i < 17; i++) begin
      send_packet(0, 6'd11, 6'd11, 8'hA5, 1'b1, 0);
    end
    check_counts("sat");
    check("sat_pass_is_f", pass_cnt, 4'hF);

    repeat (4) @(posedge aclk);
    #1;
    check("beats_outstanding", exp_q.size(), 0);
    check("verdicts_outstanding", vrd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
